mul8_nibble_seq: RTL



---
 rtl/mul8_pkg.sv | 68 ++++++
 rtl/mul8_nibble_seq_mul4x4_array.sv | 32 +++
 rtl/mul8_nibble_seq.sv | 123 ++++++++++++
 3 files changed

// File: rtl/mul8_pkg.sv
// Shared types and step tables for the nibble-serial 8x8 multiplier.
package mul8_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int NUM_STEPS = 4;

  localparam logic [3:0] SHIFT0 = 4'd0;
  localparam logic [3:0] SHIFT1 = 4'd4;
  localparam logic [3:0] SHIFT2 = 4'd4;
  localparam logic [3:0] SHIFT3 = 4'd8;

  typedef struct packed {
    logic a_hi;
    logic b_hi;
  } nib_sel_t;

  function automatic nib_sel_t step_sel(
    input logic [1:0] s
  );
    nib_sel_t r;
    r.a_hi = s[0];
    r.b_hi = s[1];
    return r;
  endfunction

  function automatic logic [3:0] step_shift(
    input logic [1:0] s
  );
    logic [3:0] r;
    unique case (s)
      2'd0: r = SHIFT0;
      2'd1: r = SHIFT1;
      2'd2: r = SHIFT2;
      2'd3: r = SHIFT3;
    endcase
    return r;
  endfunction

  // Lowest active step, 0 when the mask is empty.
  function automatic logic [1:0] first_step(
    input logic [3:0] mask
  );
    logic [1:0] r;
    r = 2'd0;
    for (int i = NUM_STEPS - 1; i >= 0; i--)
      if (mask[i]) r = 2'(i);
    return r;
  endfunction

  // {found, index} of the next active step after cur.
  function automatic logic [2:0] next_step(
    input logic [3:0] mask,
    input logic [1:0] cur
  );
    logic [2:0] r;
    r = 3'd0;
    for (int i = NUM_STEPS - 1; i >= 0; i--)
      if (mask[i] && (i > int'(cur)))
        r = {1'b1, 2'(i)};
    return r;
  endfunction

endpackage

// File: rtl/mul8_nibble_seq_mul4x4_array.sv
// Combinational 4x4 unsigned array multiplier.
// Rows of partial products summed by ripple full-adder chains.
module mul4x4_array (
  input  logic [3:0] m,
  input  logic [3:0] q,
  output logic [7:0] p
);

  logic [7:0] sum;
  logic [7:0] row;
  logic [7:0] nxt;
  logic       c;

  always_comb begin
    sum = 8'h00;
    row = 8'h00;
    nxt = 8'h00;
    c   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      row = {4'h0, m & {4{q[i]}}} << i;
      c   = 1'b0;
      for (int k = 0; k < 8; k++) begin
        nxt[k] = sum[k] ^ row[k] ^ c;
        c = (sum[k] & row[k]) |
            (c & (sum[k] ^ row[k]));
      end
      sum = nxt;
    end
    p = sum;
  end

endmodule

// File: rtl/mul8_nibble_seq.sv
// Nibble-serial 8x8 multiplier sequencer over one shared 4x4 array.
// Optional ZERO_SKIP_EN skips steps whose nibble pair contains a zero.
module mul8_nibble_seq
  import mul8_pkg::*;
#(
  parameter bit CLR_ON_POP = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] product,
  output logic        busy
);

  state_t      state_q, state_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [1:0]  step_q, step_d;
  logic [3:0]  mask_q, mask_d;
  logic [15:0] acc_q, acc_d;

  nib_sel_t    sel;
  logic [3:0]  nib_m, nib_q;
  logic [7:0]  pp;
  logic [15:0] pp_ext;
  logic [2:0]  nxt;

  function automatic logic [3:0] calc_mask(
    input logic [7:0] x,
    input logic [7:0] y
  );
`ifdef ZERO_SKIP_EN
    logic [3:0] r;
    r[0] = (|x[3:0]) & (|y[3:0]);
    r[1] = (|x[7:4]) & (|y[3:0]);
    r[2] = (|x[3:0]) & (|y[7:4]);
    r[3] = (|x[7:4]) & (|y[7:4]);
    return r;
`else
    return 4'hF | {4{x[0] & 1'b0}} | {4{y[0] & 1'b0}};
`endif
  endfunction

  assign sel   = step_sel(step_q);
  assign nib_m = sel.a_hi ? a_q[7:4] : a_q[3:0];
  assign nib_q = sel.b_hi ? b_q[7:4] : b_q[3:0];

  mul4x4_array u_arr (
    .m (nib_m),
    .q (nib_q),
    .p (pp)
  );

  assign pp_ext = {8'h00, pp} << step_shift(step_q);
  assign nxt    = next_step(mask_q, step_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    step_d  = step_q;
    mask_d  = mask_q;
    acc_d   = acc_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          acc_d   = 16'h0000;
          mask_d  = calc_mask(a, b);
          step_d  = first_step(mask_d);
          state_d = RUN;
        end
      end
      RUN: begin
        if (mask_q[step_q])
          acc_d = acc_q + pp_ext;
        if (nxt[2]) begin
          step_d = nxt[1:0];
        end else begin
          step_d  = 2'd0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
          if (CLR_ON_POP) acc_d = 16'h0000;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      step_q  <= 2'd0;
      mask_q  <= 4'h0;
      acc_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      step_q  <= step_d;
      mask_q  <= mask_d;
      acc_q   <= acc_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign out_valid = (state_q == HOLD);
  assign product   = acc_q;

endmodule
